// File: rtl/sbox_sched_pkg.sv
// ============================================================================
// Module   : sbox_sched_pkg
// Purpose  : Shared types, constants and beat-count helper for the S-box
//            lane scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sbox_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_RND = 1'b0,
        OWN_KEY = 1'b1
    } owner_t;

    localparam int RND_BYTES = 16;
    localparam int KEY_BYTES = 4;

    // Lane beats needed to cover a request; never less than one beat.
    function automatic int beats(input int bytes, input int lane);
        return (bytes + lane - 1) / lane;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sbox_lane.sv
// ============================================================================
// Module   : sbox_lane
// Purpose  : Combinational lane of LANE_BYTES parallel AES byte substitutions,
//            forward (mode 0) or inverse (mode 1) S-box.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_lane #(
    parameter int LANE_BYTES = 4
) (
    input  logic                    i_mode,
    input  logic [8*LANE_BYTES-1:0] i_data,
    output logic [8*LANE_BYTES-1:0] o_data
);

    localparam logic [0:255][7:0] C_SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] C_SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // One independent table lookup per byte slot of the lane.
    generate
        for (genvar g = 0; g < LANE_BYTES; g++) begin : g_byte
            assign o_data[8*g +: 8] = i_mode ? C_SBOX_INV[i_data[8*g +: 8]]
                                             : C_SBOX_FWD[i_data[8*g +: 8]];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sbox_scheduler.sv
// ============================================================================
// Module   : sbox_scheduler
// Purpose  : Shares one LANE_BYTES-wide S-box lane between the cipher round
//            datapath (128-bit, fwd/inv) and key expansion (32-bit SubWord,
//            fwd) with non-preemptive round-robin arbitration.
//            Optional build macro SBOX_PERF_EN adds saturating grant and
//            stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_scheduler
    import sbox_sched_pkg::*;
#(
    parameter int LANE_BYTES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rnd_valid,
    output logic         o_rnd_ready,
    input  logic         i_rnd_mode,
    input  logic [127:0] i_rnd_data,
    output logic         o_rnd_done,
    output logic [127:0] o_rnd_data,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [31:0]  i_key_data,
    output logic         o_key_done,
    output logic [31:0]  o_key_data
`ifdef SBOX_PERF_EN
    ,
    output logic [15:0]  o_rnd_grants,
    output logic [15:0]  o_key_grants,
    output logic [15:0]  o_stall_cycles
`endif
);

    localparam int c_lane_w = 8 * LANE_BYTES;
    localparam int c_rnd_n  = beats(RND_BYTES, LANE_BYTES);
    localparam int c_key_n  = beats(KEY_BYTES, LANE_BYTES);

    generate
        if (!(LANE_BYTES == 4 || LANE_BYTES == 8 || LANE_BYTES == 16)) begin : g_bad_lane
            $error("sbox_scheduler: LANE_BYTES must be 4, 8 or 16");
        end
    endgenerate

    state_t               r_state;
    owner_t               r_owner;
    owner_t               r_ptr;
    logic                 r_mode;
    logic [127:0]         r_data;
    logic [1:0]           r_beat;
    logic [127:0]         r_rnd_data;
    logic [31:0]          r_key_data;
    logic                 r_rnd_done;
    logic                 r_key_done;

    logic                 w_rnd_grant;
    logic                 w_key_grant;
    logic                 w_last_beat;
    logic                 w_lane_mode;
    logic [c_lane_w-1:0]  w_lane_in;
    logic [c_lane_w-1:0]  w_lane_out;

    // Readiness looks only at the competing requester's valid and the pointer.
    assign o_rnd_ready = (r_state == IDLE) & ~(i_key_valid & (r_ptr == OWN_KEY));
    assign o_key_ready = (r_state == IDLE) & ~(i_rnd_valid & (r_ptr == OWN_RND));
    assign w_rnd_grant = i_rnd_valid & o_rnd_ready;
    assign w_key_grant = i_key_valid & o_key_ready;

    assign w_last_beat = (r_owner == OWN_RND) ? (r_beat == 2'(c_rnd_n - 1))
                                              : (r_beat == 2'(c_key_n - 1));
    assign w_lane_mode = (r_owner == OWN_RND) & r_mode;

    // Lane input: round beats walk down from the MS bytes; key sits in the low slots.
    always_comb begin
        w_lane_in = '0;
        if (r_owner == OWN_KEY) begin
            w_lane_in[31:0] = r_data[31:0];
        end else begin
            for (int b = 0; b < c_rnd_n; b++) begin
                if (r_beat == 2'(b)) begin
                    w_lane_in = r_data[127 - c_lane_w*b -: c_lane_w];
                end
            end
        end
    end

    sbox_lane #(
        .LANE_BYTES (LANE_BYTES)
    ) u_lane (
        .i_mode (w_lane_mode),
        .i_data (w_lane_in),
        .o_data (w_lane_out)
    );

    // Arbitration FSM, beat sequencing and registered results / done pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_RND;
            r_ptr      <= OWN_RND;
            r_mode     <= 1'b0;
            r_data     <= '0;
            r_beat     <= '0;
            r_rnd_data <= '0;
            r_key_data <= '0;
            r_rnd_done <= 1'b0;
            r_key_done <= 1'b0;
        end else begin
            r_rnd_done <= 1'b0;
            r_key_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rnd_grant) begin
                        r_owner    <= OWN_RND;
                        r_ptr      <= OWN_KEY;
                        r_mode     <= i_rnd_mode;
                        r_data     <= i_rnd_data;
                        r_rnd_data <= '0;
                        r_beat     <= '0;
                        r_state    <= RUN;
                    end else if (w_key_grant) begin
                        r_owner    <= OWN_KEY;
                        r_ptr      <= OWN_RND;
                        r_mode     <= 1'b0;
                        r_data     <= {96'd0, i_key_data};
                        r_key_data <= '0;
                        r_beat     <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (r_owner == OWN_RND) begin
                        for (int b = 0; b < c_rnd_n; b++) begin
                            if (r_beat == 2'(b)) begin
                                r_rnd_data[127 - c_lane_w*b -: c_lane_w] <= w_lane_out;
                            end
                        end
                    end else begin
                        r_key_data <= w_lane_out[31:0];
                    end
                    if (w_last_beat) begin
                        r_state <= DONE;
                        if (r_owner == OWN_RND) begin
                            r_rnd_done <= 1'b1;
                        end else begin
                            r_key_done <= 1'b1;
                        end
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rnd_done = r_rnd_done;
    assign o_rnd_data = r_rnd_data;
    assign o_key_done = r_key_done;
    assign o_key_data = r_key_data;

`ifdef SBOX_PERF_EN
    logic [15:0] r_rnd_grants;
    logic [15:0] r_key_grants;
    logic [15:0] r_stall_cycles;
    logic        w_stall;

    assign w_stall = (i_rnd_valid & ~o_rnd_ready) | (i_key_valid & ~o_key_ready);

    // Saturating grant and stall counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rnd_grants   <= '0;
            r_key_grants   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_rnd_grant && (r_rnd_grants != 16'hFFFF)) begin
                r_rnd_grants <= r_rnd_grants + 16'd1;
            end
            if (w_key_grant && (r_key_grants != 16'hFFFF)) begin
                r_key_grants <= r_key_grants + 16'd1;
            end
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign o_rnd_grants   = r_rnd_grants;
    assign o_key_grants   = r_key_grants;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire
